// File: rtl/bitwise_gate_pipe.sv
// Registered bitwise gate unit with valid/ready on both sides and one full-throughput stage.
// Accumulate mode replaces operand B with a running register for XOR checksums and AND/OR masks.
module bitwise_gate_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             parity,
   output logic             zero,
   output logic [CNT_W-1:0] xfer_cnt
);

   // Handshake: a beat moves on a side when valid && ready at the rising edge;
   // in_ready is combinational (free slot or slot draining this cycle).
   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] res;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             parity_q, parity_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid_q && out_ready;

   always_comb begin
      b_eff = b;
      if (acc_mode) begin
         b_eff = acc_clr ? '0 : acc_q;
      end
   end

   always_comb begin
      res = a;
      case (op)
         3'b000: res = a & b_eff;
         3'b001: res = a | b_eff;
         3'b010: res = a ^ b_eff;
         3'b011: res = ~(a & b_eff);
         3'b100: res = ~(a | b_eff);
         3'b101: res = ~(a ^ b_eff);
         3'b110: res = ~a;
         3'b111: res = a;
         default: res = a;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      c_d         = c_q;
      parity_d    = parity_q;
      zero_d      = zero_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      if (xfer) begin
         out_valid_d = 1'b0;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         c_d         = res;
         parity_d    = ^res;
         zero_d      = (res == '0);
         // acc_clr outside accumulate mode only wipes the register for later beats
         if (acc_mode) acc_d = res;
         else if (acc_clr) acc_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         c_q         <= '0;
         parity_q    <= 1'b0;
         zero_q      <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         parity_q    <= parity_d;
         zero_q      <= zero_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign c         = c_q;
   assign parity    = parity_q;
   assign zero      = zero_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_bitwise_gate_pipe.sv
// Directed bench: a 3-bit instance for the XOR stream, an 8-bit instance with a 2-bit counter for the rest.
module tb_bitwise_gate_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // 3-bit instance
   logic       v3 = 1'b0, rdy3, ov3, or3 = 1'b1, par3, zero3;
   logic [2:0] a3 = '0, b3 = '0, op3 = '0, c3;
   logic       am3 = 1'b0, ac3 = 1'b0;
   logic [15:0] cnt3;

   bitwise_gate_pipe #(.WIDTH(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .a(a3), .b(b3), .op(op3),
      .acc_mode(am3), .acc_clr(ac3), .out_valid(ov3), .out_ready(or3), .c(c3),
      .parity(par3), .zero(zero3), .xfer_cnt(cnt3)
   );

   // 8-bit instance, 2-bit counter
   logic       v8 = 1'b0, rdy8, ov8, or8 = 1'b1, par8, zero8;
   logic [7:0] a8 = '0, b8 = '0, c8;
   logic [2:0] op8 = '0;
   logic       am8 = 1'b0, ac8 = 1'b0;
   logic [1:0] cnt8;

   bitwise_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
      .acc_mode(am8), .acc_clr(ac8), .out_valid(ov8), .out_ready(or8), .c(c8),
      .parity(par8), .zero(zero8), .xfer_cnt(cnt8)
   );

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic am, input logic ac);
      v8 = 1'b1; a8 = a; b8 = b; op8 = op; am8 = am; ac8 = ac;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if ({ov3, c3, par3, zero3} !== 6'b0) begin bad++; $display("FAIL reset3 got=%b want=000000", {ov3, c3, par3, zero3}); end
      total++; if (cnt3 !== 16'd0) begin bad++; $display("FAIL reset3_cnt got=%0d want=0", cnt3); end
      total++; if ({ov8, c8, par8, zero8, cnt8} !== 13'b0) begin bad++; $display("FAIL reset8 got=%b want=0", {ov8, c8, par8, zero8, cnt8}); end
      @(negedge clk); rst = 1'b0;
      #1;
      total++; if (rdy3 !== 1'b1 || rdy8 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b%b want=11", rdy3, rdy8); end
   endtask

   task automatic test_xor3();
      logic [2:0] av[4] = '{3'b000, 3'b111, 3'b000, 3'b001};
      logic [2:0] bv[4] = '{3'b010, 3'b011, 3'b101, 3'b100};
      logic [2:0] cv[4] = '{3'b010, 3'b100, 3'b101, 3'b101};
      logic       pv[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      @(negedge clk);
      or3 = 1'b1; op3 = 3'b010;
      for (int i = 0; i < 4; i++) begin
         v3 = 1'b1; a3 = av[i]; b3 = bv[i];
         tick();
         total++; if (c3 !== cv[i] || ov3 !== 1'b1) begin bad++; $display("FAIL xor3_c[%0d] got=%b ov=%b want=%b ov=1", i, c3, ov3, cv[i]); end
         total++; if (par3 !== pv[i]) begin bad++; $display("FAIL xor3_par[%0d] got=%b want=%b", i, par3, pv[i]); end
      end
      v3 = 1'b0;
      tick();
      total++; if (cnt3 !== 16'd4 || ov3 !== 1'b0) begin bad++; $display("FAIL xor3_cnt got=%0d ov=%b want=4 ov=0", cnt3, ov3); end
   endtask

   task automatic test_all_ops();
      logic [7:0] ev[8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
      or8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive8(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0);
         tick();
         total++; if (c8 !== ev[i] || zero8 !== 1'b0 || ov8 !== 1'b1) begin bad++; $display("FAIL op%0d got=%h z=%b ov=%b want=%h z=0 ov=1", i, c8, zero8, ov8, ev[i]); end
      end
      v8 = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      or8 = 1'b0;
      drive8(8'hAA, 8'h55, 3'b010, 1'b0, 1'b0);
      tick();
      total++; if (c8 !== 8'hFF || ov8 !== 1'b1) begin bad++; $display("FAIL bp_first got=%h ov=%b want=ff ov=1", c8, ov8); end
      drive8(8'h0F, 8'h0F, 3'b000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         total++; if (rdy8 !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, rdy8); end
         tick();
         total++; if (c8 !== 8'hFF || ov8 !== 1'b1 || par8 !== 1'b0) begin bad++; $display("FAIL bp_hold[%0d] got=%h ov=%b p=%b want=ff ov=1 p=0", i, c8, ov8, par8); end
      end
      or8 = 1'b1;
      #1;
      total++; if (rdy8 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", rdy8); end
      tick();
      total++; if (c8 !== 8'h0F || ov8 !== 1'b1) begin bad++; $display("FAIL bp_release got=%h ov=%b want=0f ov=1", c8, ov8); end
      v8 = 1'b0;
      tick();
      total++; if (ov8 !== 1'b0 || c8 !== 8'h0F) begin bad++; $display("FAIL bp_drain got=%h ov=%b want=0f ov=0", c8, ov8); end
   endtask

   task automatic test_accumulate();
      logic [7:0] av[4] = '{8'h11, 8'h22, 8'h44, 8'h05};
      logic       cl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] ev[4] = '{8'h11, 8'h33, 8'h77, 8'h05};
      or8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive8(av[i], 8'hFF, 3'b010, 1'b1, cl[i]);
         tick();
         total++; if (c8 !== ev[i]) begin bad++; $display("FAIL acc[%0d] got=%h want=%h", i, c8, ev[i]); end
      end
      v8 = 1'b0; ac8 = 1'b0;
      tick();
   endtask

   task automatic test_reset_midstream();
      or8 = 1'b0;
      drive8(8'h5A, 8'h00, 3'b010, 1'b1, 1'b1);
      tick();
      v8 = 1'b0;
      total++; if (c8 !== 8'h5A || ov8 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%h ov=%b want=5a ov=1", c8, ov8); end
      #2 rst = 1'b1;
      #1;
      total++; if ({ov8, c8, par8, zero8, cnt8} !== 13'b0) begin bad++; $display("FAIL mid_async got=%b want=0", {ov8, c8, par8, zero8, cnt8}); end
      @(negedge clk); rst = 1'b0;
      or8 = 1'b1;
      drive8(8'h0A, 8'hFF, 3'b010, 1'b1, 1'b0);
      tick();
      total++; if (c8 !== 8'h0A || ov8 !== 1'b1) begin bad++; $display("FAIL mid_post got=%h ov=%b want=0a ov=1", c8, ov8); end
      v8 = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      logic [1:0] ev[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      total++; if (cnt8 !== 2'd0) begin bad++; $display("FAIL sat_start got=%0d want=0", cnt8); end
      or8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive8(8'h01, 8'h01, 3'b000, 1'b0, 1'b0);
         tick();
         v8 = 1'b0;
         tick();
         total++; if (cnt8 !== ev[i]) begin bad++; $display("FAIL sat[%0d] got=%0d want=%0d", i, cnt8, ev[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_xor3();
      test_all_ops();
      test_backpressure();
      test_accumulate();
      test_reset_midstream();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
